// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and defaults for the debounce/edge-detect block
// Contents: deb_state_e FSM encoding, default synchroniser depth and debounce length.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    PEND_HIGH = 2'd1,
    ST_HIGH   = 2'd2,
    PEND_LOW  = 2'd3
  } deb_state_e;

  localparam int DEB_SYNC_STAGES_DEF = 2;
  localparam int DEB_CYCLES_DEF      = 4;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchroniser for one asynchronous bit
// Ports: clk (rising edge), rst_n (sync, active-low, clears every stage),
//        d (asynchronous input), q (last synchroniser stage).
// Parameter STAGES: number of flops, 2 or more.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// rtl/debounce_edge_detect.sv - synchronise, debounce and edge-detect one level input
// Ports: clk (rising edge), rst_n (sync, active-low), din (asynchronous raw level),
//        dout (debounced level), rise/fall (registered one-cycle strobes on dout change),
//        edge_cnt (8-bit count of dout changes, mod 256).
// Build option: define DEBOUNCE_EDGE_CNT_EN to build the edge counter; otherwise
//        edge_cnt is tied to zero.
module debounce_edge_detect
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEB_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic [7:0] edge_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sy;
  deb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             commit;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (din),
    .q    (sy)
  );

  // A commit happens on the edge where the final required differing sample
  // arrives. With a one-cycle filter the stable states commit directly.
  always_comb begin
    commit = 1'b0;
    unique case (state)
      ST_LOW, ST_HIGH:     commit = (sy != dout) && (DEBOUNCE_CYCLES == 1);
      PEND_HIGH, PEND_LOW: commit = (sy != dout) && (cnt == CNT_LAST);
      default:             commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (commit) begin
        state <= dout ? ST_LOW : ST_HIGH;
        cnt   <= '0;
        dout  <= ~dout;
        rise  <= ~dout;
        fall  <= dout;
      end else begin
        unique case (state)
          ST_LOW: begin
            if (sy) begin
              state <= PEND_HIGH;
              cnt   <= CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!sy) begin
              state <= PEND_LOW;
              cnt   <= CNT_ONE;
            end
          end
          // sy matching the current level wins over a pending count: glitch rejected.
          PEND_HIGH: begin
            if (!sy) begin
              state <= ST_LOW;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          PEND_LOW: begin
            if (sy) begin
              state <= ST_HIGH;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_LOW;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] edge_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edge_q <= 8'd0;
    end else if (commit) begin
      edge_q <= edge_q + 8'd1;
    end
  end

  assign edge_cnt = edge_q;
`else
  assign edge_cnt = 8'd0;
`endif

endmodule

// File: doc/debounce_edge_detect.md
# debounce_edge_detect

Conditions the single-bit `Q` output of the D flip-flop stage for downstream logic. The block resynchronises the bit into the `clk` domain and debounces it with a consecutive-cycle filter. It then publishes a stable level plus one-cycle rise/fall strobes, so control FSMs can consume a glitch-free event stream.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth in flops; legal range ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive differing synchronised samples required before the level flips; legal range ≥1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  1  raw level, which is the upstream flip-flop `Q`; treated as asynchronous.
- `dout`  out  1  debounced level.
- `rise`  out  1  one-cycle strobe on the `dout` 0→1 change.
- `fall`  out  1  one-cycle strobe on the `dout` 1→0 change.
- `edge_cnt`  out  8  count of `dout` changes; see Configuration.

## Operation
- The synchroniser chain `s[0..SYNC_STAGES-1]` shifts `din` in every edge. `sy` = last stage.
- FSM states and counter behaviour:
  - `ST_LOW`: `dout`=0. If `sy`=1, go to `PEND_HIGH` with cnt=1. If `DEBOUNCE_CYCLES`=1, commit immediately instead.
  - `PEND_HIGH`: if `sy`=0, return to `ST_LOW` with cnt=0 (glitch rejected). Else if cnt=`DEBOUNCE_CYCLES`-1, go to `ST_HIGH` and set `dout`=1, `rise`=1, cnt=0. Else cnt+1.
  - `ST_HIGH` / `PEND_LOW`: mirror image of the above, asserting `fall` on commit.
- Counter never exceeds `DEBOUNCE_CYCLES`-1 and saturates at no other value. No wrap is possible.
- `rise` and `fall` are registered. They are high only in the cycle immediately after the committing edge, and are never high together.
- Reset, applied at any time including mid-PEND, has the same effect: all sync flops=0, state=`ST_LOW`, cnt=0, `dout`=0, `rise`=0, `fall`=0, `edge_cnt`=0.
- After reset, a `din` that is already 1 is treated as a genuine rise. It produces `rise` after full latency.

## Timing
- Latency: `dout` and its strobe update on the (`SYNC_STAGES`+`DEBOUNCE_CYCLES`)-th rising edge after `din` changes. This assumes `din` is held stable and the first sync flop captures it on the first of those edges.
- A pulse on `sy` shorter than `DEBOUNCE_CYCLES` cycles produces no output change and no strobe.
- A return to the current level in the same cycle the counter would commit cancels the commit, because the `sy` check has priority.
- `rst_n` is sampled on `clk` only. Its deassertion takes effect at the first edge where it is sampled high.
- Minimum spacing between `rise` and `fall` strobes: `DEBOUNCE_CYCLES` cycles.

## Configuration
- `DEBOUNCE_EDGE_CNT_EN` defined: `edge_cnt` increments (mod 256, wraps 255→0) on every committed change, whether `rise` or `fall`.
- `DEBOUNCE_EDGE_CNT_EN` undefined: the counter is not built and `edge_cnt` is tied to 8'd0. All other behaviour is identical.

## Structure
- `debounce_pkg` holds:
  - the state enum `deb_state_e` (`ST_LOW`, `PEND_HIGH`, `ST_HIGH`, `PEND_LOW`);
  - default constants `DEB_SYNC_STAGES_DEF`=2 and `DEB_CYCLES_DEF`=4.
- One sub-module, `sync_chain`. It is parameterised by depth, uses the same reset, and is reusable for any other async single-bit input.

## Test plan
- Defaults, `din` 0→1 held: `dout`=1 and `rise`=1 for exactly one cycle, on the 6th edge after the change. `fall` stays 0.
- `din` high for 3 cycles then low: no `dout` change and no strobes. FSM returns to `ST_LOW`.
- `din` 1→0 after a settled high: `fall` pulses once on the 6th edge, then `dout`=0. With `DEBOUNCE_EDGE_CNT_EN`, `edge_cnt`=2.
- `rst_n`=0 asserted during `PEND_HIGH` (cnt=2): next edge gives `dout`=0, cnt=0, no strobe. After release with `din`=1, `rise` fires 6 edges later.
- `DEBOUNCE_CYCLES`=1, `SYNC_STAGES`=3: `din` toggle produces a `dout` change on the 4th edge. Alternating `din` every 4 cycles yields alternating `rise`/`fall`.
- With the macro defined, 256 committed changes: `edge_cnt` wraps to 0. Without the macro, `edge_cnt` stays 0 throughout.
